seq_multiplier_n: RTL
=====================

SEQ_MULTIPLIER_N -- requirements
Module: seq_multiplier_n

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand width, legal range 4..32.
REQ-002 The module SHALL have port Clk, input, 1 bit, the sole clock; all state updates on its rising edge.
REQ-003 The module SHALL have port Reset, input, 1 bit, synchronous active-high reset.
REQ-004 The module SHALL have port ClearA_LoadB, input, 1 bit: in IDLE, load B from Din and clear X:A.
REQ-005 The module SHALL have port Run, input, 1 bit: level-sampled start request.
REQ-006 The module SHALL have port Signed_Mode, input, 1 bit: 1 = two's-complement operands, 0 = unsigned.
REQ-007 The module SHALL have port Din, input, WIDTH bits: multiplicand source at start and multiplier source at load.
REQ-008 The module SHALL have port Aval, output, WIDTH bits: A register, the upper product half.
REQ-009 The module SHALL have port Bval, output, WIDTH bits: B register, the lower product half.
REQ-010 The module SHALL have port Xval, output, 1 bit: X extension bit.
REQ-011 The module SHALL have port Busy, output, 1 bit: high in CLR, ADD and SHIFT.
REQ-012 The module SHALL have port Done, output, 1 bit: high only in HOLD.

Function
REQ-013 States SHALL be IDLE, CLR, ADD, SHIFT and HOLD, plus a step counter of ceil(log2(WIDTH))+1 bits.
REQ-014 IDLE with ClearA_LoadB=1 SHALL give, next edge: B<=Din, X<=0, A<=0, state stays IDLE.
REQ-015 IDLE with Run=1 and ClearA_LoadB=0 SHALL give, next edge: S<=Din, Mode<=Signed_Mode, state<=CLR.
REQ-016 ClearA_LoadB and Run both high in IDLE SHALL perform the load only; the start waits for a later cycle with Run=1.
REQ-017 CLR SHALL clear X and A, clear the counter, and go to ADD after one cycle.
REQ-018 In ADD with B[0]=0, X, A and S SHALL stay unchanged.
REQ-019 In ADD with B[0]=1, signed mode and counter<WIDTH-1, X:A SHALL become sext(A)+sext(S), (WIDTH+1)-bit.
REQ-020 In ADD with B[0]=1, signed mode and counter=WIDTH-1, X:A SHALL become sext(A)-sext(S), (WIDTH+1)-bit.
REQ-021 In ADD with B[0]=1 in unsigned mode, X:A SHALL become zext(A)+zext(S), X being the carry-out.
REQ-022 SHIFT SHALL shift {X,A,B} right by 1 with A[WIDTH-1]<=X and B[WIDTH-1]<=old A[0], then increment the counter.
REQ-023 In SHIFT, signed mode SHALL keep X unchanged; unsigned mode SHALL set X<=0.
REQ-024 SHIFT SHALL go to ADD while the incremented counter<WIDTH, else to HOLD.
REQ-025 Latency SHALL be exactly 2*WIDTH+1 cycles from the start-sampling edge to Done=1.
REQ-026 The final product SHALL be {Aval,Bval}, 2*WIDTH bits.
REQ-027 HOLD SHALL keep all registers unchanged while Run=1, and go to IDLE on the first edge with Run=0 (one multiply per Run press).
REQ-028 Run, ClearA_LoadB, Din and Signed_Mode SHALL be ignored in CLR, ADD and SHIFT; S and Mode latched at start are used.
REQ-029 ClearA_LoadB SHALL be ignored in HOLD.
REQ-030 A new start from IDLE SHALL reuse the current B (previous low half) as the multiplier.
REQ-031 Busy and Done SHALL be registered-state decodes, never both high.

Reset
REQ-032 Reset=1 SHALL, at the next edge in any state including mid-multiply, set state IDLE, A=0, B=0, X=0, S=0, Mode=0, counter=0, Busy=0, Done=0.
REQ-033 Reset SHALL take priority over all other inputs; no partial result SHALL survive it.

Verification (WIDTH=8)
REQ-034 Bench SHALL check: load B=0xFD, start signed with Din=0x07 -> after 17 cycles Done=1, A=0xFF, B=0xEB, X=1.
REQ-035 Bench SHALL check: load B=0xFD, start unsigned with Din=0x07 -> A=0x06, B=0xEB, X=0.
REQ-036 Bench SHALL check: signed 0x80*0x80 -> A=0x40, B=0x00; unsigned 0xFF*0xFF -> A=0xFE, B=0x01.
REQ-037 Bench SHALL check: Run held 40 cycles -> exactly one multiply, Done stays 1 until Run=0, then IDLE.
REQ-038 Bench SHALL check: Reset asserted at cycle 6 of a multiply -> next cycle all outputs 0, state IDLE; Din changes mid-run have no effect.
REQ-039 Bench SHALL check: ClearA_LoadB and Run high together in IDLE -> B loaded, Busy stays 0 that cycle.

Source files
------------

// File: rtl/seq_multiplier_n.sv
// seq_multiplier_n
//   Sequential shift-and-add multiplier for unsigned or two's-complement
//   operands. The multiplier is loaded into B beforehand. The multiplicand is
//   captured into S when a multiply starts. The 2*WIDTH-bit product is left in
//   {A,B}, with X as the extension bit above A.
//
// Handshake: Run is level-sampled in IDLE. A start lasts 2*WIDTH+1 cycles up to
//   Done, which stays high while Run is held. Dropping Run returns to IDLE.
//
// Ports
//   Clk          in   sole clock, rising edge
//   Reset        in   synchronous, active-high, highest priority
//   ClearA_LoadB in   in IDLE: B <= Din, X:A <= 0 (takes precedence over Run)
//   Run          in   start request (IDLE); hold/release control (HOLD)
//   Signed_Mode  in   1 = two's complement, 0 = unsigned; sampled at start
//   Din          in   multiplier at load, multiplicand at start
//   Aval         out  A register, upper product half
//   Bval         out  B register, lower product half
//   Xval         out  X extension bit
//   Busy         out  high in CLR, ADD, SHIFT
//   Done         out  high in HOLD only
//   dbg_state    out  encoded FSM state (IDLE=0 CLR=1 ADD=2 SHIFT=3 HOLD=4)
module seq_multiplier_n #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ClearA_LoadB,
  input  logic             Run,
  input  logic             Signed_Mode,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             Xval,
  output logic             Busy,
  output logic             Done,
  output logic [2:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] s_reg;
  logic             x_reg;
  logic             mode;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   ext_a;
  logic [WIDTH:0]   ext_s;
  logic [WIDTH:0]   add_res;
  logic [CW-1:0]    cnt_inc;

  // In signed mode the last partial product carries negative weight
  // (the multiplier's sign bit), so the final step subtracts.
  always_comb begin
    ext_a   = mode ? {a_reg[WIDTH-1], a_reg} : {1'b0, a_reg};
    ext_s   = mode ? {s_reg[WIDTH-1], s_reg} : {1'b0, s_reg};
    add_res = ext_a + ext_s;
    if (mode && (cnt == CW'(WIDTH - 1))) begin
      add_res = ext_a - ext_s;
    end
    cnt_inc = cnt + CW'(1);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      s_reg <= '0;
      x_reg <= 1'b0;
      mode  <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ClearA_LoadB) begin
            b_reg <= Din;
            a_reg <= '0;
            x_reg <= 1'b0;
          end else if (Run) begin
            s_reg <= Din;
            mode  <= Signed_Mode;
            state <= CLR;
          end
        end
        CLR: begin
          a_reg <= '0;
          x_reg <= 1'b0;
          cnt   <= '0;
          state <= ADD;
        end
        ADD: begin
          if (b_reg[0]) begin
            {x_reg, a_reg} <= add_res;
          end
          state <= SHIFT;
        end
        SHIFT: begin
          a_reg <= {x_reg, a_reg[WIDTH-1:1]};
          b_reg <= {a_reg[0], b_reg[WIDTH-1:1]};
          x_reg <= mode ? x_reg : 1'b0;
          cnt   <= cnt_inc;
          state <= (cnt_inc < CW'(WIDTH)) ? ADD : HOLD;
        end
        HOLD: begin
          if (!Run) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Aval      = a_reg;
  assign Bval      = b_reg;
  assign Xval      = x_reg;
  assign Busy      = (state == CLR) || (state == ADD) || (state == SHIFT);
  assign Done      = (state == HOLD);
  assign dbg_state = state;

endmodule
